alarm_watch_core: RTL and testbench

Single-clock successor to the divided-clock watch top. It contains on-chip tick prescalers, a BCD HH:MM:SS timekeeper with validated load, and an alarm register with a ring/snooze state machine. It also drives a parametrised multiplexed 7-segment display. All logic runs on clk, and the internal divisors produce one-cycle enable ticks, never derived clocks.

---
 rtl/alarm_watch_core.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_alarm_watch_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_watch_core.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_watch_core
//  Brief    : Single-clock BCD watch with alarm/snooze FSM and 7-seg scanner.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_watch_core #(
    parameter int TICK_DIV       = 10000,
    parameter int DISP_DIV       = 100,
    parameter int NUM_DIGITS     = 8,
    parameter int RING_SEC       = 60,
    parameter int SNOOZE_MIN     = 5,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [15:0]           time_init,
    input  logic                  alarm_set,
    input  logic [15:0]           alarm_init,
    input  logic                  alarm_en,
    input  logic                  snooze,
    input  logic                  stop,
    input  logic                  disp_alarm,
    output logic [3:0]            hourdec_now,
    output logic [3:0]            hourone_now,
    output logic [3:0]            mindec_now,
    output logic [3:0]            minone_now,
    output logic [7:0]            sec_now,
    output logic                  ring,
    output logic                  load_err,
    output logic                  CA,
    output logic                  CB,
    output logic                  CC,
    output logic                  CD,
    output logic                  CE,
    output logic                  CF,
    output logic                  CG,
    output logic [NUM_DIGITS-1:0] AN
);

    localparam int c_TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DW         = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam int c_SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int c_CNT_MAX    = (RING_SEC > c_SNOOZE_SEC) ? RING_SEC : c_SNOOZE_SEC;
    localparam int c_CW         = $clog2(c_CNT_MAX + 1);

    localparam logic [c_TW-1:0]       c_TICK_LAST   = c_TW'(TICK_DIV - 1);
    localparam logic [c_TW-1:0]       c_TICK_HALF   = c_TW'(TICK_DIV / 2);
    localparam logic [c_DW-1:0]       c_DISP_LAST   = c_DW'(DISP_DIV - 1);
    localparam logic [c_CW-1:0]       c_RING_LOAD   = c_CW'(RING_SEC);
    localparam logic [c_CW-1:0]       c_SNOOZE_LOAD = c_CW'(c_SNOOZE_SEC);
    localparam logic [2:0]            c_DIG_LAST    = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE      = NUM_DIGITS'(1);
    localparam logic [3:0]            c_BLANK       = 4'hF;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RING   = 2'd1;
    localparam logic [1:0] c_ST_SNOOZE = 2'd2;

    // Packed HHMM is valid when each digit is decimal and the clock range holds.
    function automatic logic f_valid(input logic [15:0] v);
        logic hours_ok;
        if (v[15:12] < 4'd2)
            hours_ok = (v[11:8] <= 4'd9);
        else
            hours_ok = (v[15:12] == 4'd2) && (v[11:8] <= 4'd3);
        return hours_ok && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Active-high {a,b,c,d,e,f,g}; anything outside 0-9 stays dark.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    logic [c_TW-1:0]       r_sec_cnt;
    logic [c_DW-1:0]       r_disp_cnt;
    logic [3:0]            r_hd, r_ho, r_md, r_mo, r_sd, r_so;
    logic [15:0]           r_alarm;
    logic [1:0]            r_state;
    logic [c_CW-1:0]       r_cnt;
    logic                  r_load_err;
    logic [2:0]            r_dig_idx;
    logic [NUM_DIGITS-1:0] r_an_sel;
    logic [6:0]            r_seg;
    logic                  r_blink;

    logic                  w_sec_tick, w_disp_tick;
    logic                  w_load_ok, w_alarm_ok, w_adv, w_match;
    logic [c_TW-1:0]       w_sec_cnt_nxt;
    logic [3:0]            w_nxt_hd, w_nxt_ho, w_nxt_md, w_nxt_mo, w_nxt_sd, w_nxt_so;
    logic [1:0]            w_state_nxt;
    logic [c_CW-1:0]       w_cnt_nxt;
    logic [3:0]            w_dig_code;
    logic [NUM_DIGITS-1:0] w_an_act;

    assign w_sec_tick    = (r_sec_cnt == c_TICK_LAST);
    assign w_disp_tick   = (r_disp_cnt == c_DISP_LAST);
    assign w_load_ok     = load && f_valid(time_init);
    assign w_alarm_ok    = alarm_set && f_valid(alarm_init);
    assign w_adv         = w_sec_tick && !w_load_ok;
    assign w_sec_cnt_nxt = (w_load_ok || w_sec_tick) ? '0 : r_sec_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_cnt  <= '0;
            r_disp_cnt <= '0;
        end else begin
            r_sec_cnt  <= w_sec_cnt_nxt;
            r_disp_cnt <= w_disp_tick ? '0 : r_disp_cnt + 1'b1;
        end
    end

    // BCD increment with carries cascading up to the 23:59:59 wrap.
    always_comb begin
        w_nxt_so = r_so + 4'd1;
        w_nxt_sd = r_sd;
        w_nxt_mo = r_mo;
        w_nxt_md = r_md;
        w_nxt_ho = r_ho;
        w_nxt_hd = r_hd;
        if (r_so == 4'd9) begin
            w_nxt_so = 4'd0;
            if (r_sd != 4'd5) begin
                w_nxt_sd = r_sd + 4'd1;
            end else begin
                w_nxt_sd = 4'd0;
                if (r_mo != 4'd9) begin
                    w_nxt_mo = r_mo + 4'd1;
                end else begin
                    w_nxt_mo = 4'd0;
                    if (r_md != 4'd5) begin
                        w_nxt_md = r_md + 4'd1;
                    end else begin
                        w_nxt_md = 4'd0;
                        if ((r_hd == 4'd2) && (r_ho == 4'd3)) begin
                            w_nxt_hd = 4'd0;
                            w_nxt_ho = 4'd0;
                        end else if (r_ho == 4'd9) begin
                            w_nxt_ho = 4'd0;
                            w_nxt_hd = r_hd + 4'd1;
                        end else begin
                            w_nxt_ho = r_ho + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hd       <= 4'd0;
            r_ho       <= 4'd0;
            r_md       <= 4'd0;
            r_mo       <= 4'd0;
            r_sd       <= 4'd0;
            r_so       <= 4'd0;
            r_alarm    <= 16'h0000;
            r_load_err <= 1'b0;
        end else begin
            if (w_load_ok) begin
                {r_hd, r_ho, r_md, r_mo} <= time_init;
                r_sd <= 4'd0;
                r_so <= 4'd0;
            end else if (w_sec_tick) begin
                r_hd <= w_nxt_hd;
                r_ho <= w_nxt_ho;
                r_md <= w_nxt_md;
                r_mo <= w_nxt_mo;
                r_sd <= w_nxt_sd;
                r_so <= w_nxt_so;
            end
            if (w_alarm_ok)
                r_alarm <= alarm_init;
            r_load_err <= (load && !f_valid(time_init)) ||
                          (alarm_set && !f_valid(alarm_init));
        end
    end

    assign w_match = w_adv && alarm_en && (w_nxt_sd == 4'd0) && (w_nxt_so == 4'd0) &&
                     ({w_nxt_hd, w_nxt_ho, w_nxt_md, w_nxt_mo} == r_alarm);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // One shared down-counter serves both ring duration and snooze length.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!alarm_en) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_match) begin
                        w_state_nxt = c_ST_RING;
                        w_cnt_nxt   = c_RING_LOAD;
                    end
                end
                c_ST_RING: begin
                    if (stop) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (snooze) begin
                        w_state_nxt = c_ST_SNOOZE;
                        w_cnt_nxt   = c_SNOOZE_LOAD;
                    end else if (w_sec_tick) begin
                        if (r_cnt <= c_CW'(1)) begin
                            w_state_nxt = c_ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                end
                c_ST_SNOOZE: begin
                    if (stop) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_sec_tick) begin
                        if (r_cnt <= c_CW'(1)) begin
                            w_state_nxt = c_ST_RING;
                            w_cnt_nxt   = c_RING_LOAD;
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_dig_code = c_BLANK;
        case (r_dig_idx)
            3'd0:    w_dig_code = disp_alarm ? c_BLANK        : r_so;
            3'd1:    w_dig_code = disp_alarm ? c_BLANK        : r_sd;
            3'd2:    w_dig_code = disp_alarm ? r_alarm[3:0]   : r_mo;
            3'd3:    w_dig_code = disp_alarm ? r_alarm[7:4]   : r_md;
            3'd4:    w_dig_code = disp_alarm ? r_alarm[11:8]  : r_ho;
            3'd5:    w_dig_code = disp_alarm ? r_alarm[15:12] : r_hd;
            default: w_dig_code = c_BLANK;
        endcase
    end

    // Blink flag is registered from next-cycle values so it lines up with ring.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig_idx <= 3'd0;
            r_an_sel  <= '0;
            r_seg     <= 7'd0;
            r_blink   <= 1'b0;
        end else begin
            r_blink <= (w_state_nxt == c_ST_RING) && (w_sec_cnt_nxt < c_TICK_HALF);
            if (w_disp_tick) begin
                r_an_sel  <= c_AN_ONE << r_dig_idx;
                r_seg     <= f_seg(w_dig_code);
                r_dig_idx <= (r_dig_idx == c_DIG_LAST) ? 3'd0 : r_dig_idx + 3'd1;
            end
        end
    end

    assign w_an_act = r_blink ? '0 : r_an_sel;

    generate
        if (SEG_ACTIVE_LOW != 0) begin : g_active_low
            assign AN                           = ~w_an_act;
            assign {CA, CB, CC, CD, CE, CF, CG} = ~r_seg;
        end else begin : g_active_high
            assign AN                           = w_an_act;
            assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;
        end
    endgenerate

    assign hourdec_now = r_hd;
    assign hourone_now = r_ho;
    assign mindec_now  = r_md;
    assign minone_now  = r_mo;
    assign sec_now     = {r_sd, r_so};
    assign ring        = (r_state == c_ST_RING);
    assign load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_alarm_watch_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_watch_core
//  Brief    : Scenario bench for alarm_watch_core with queued expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_watch_core;

    localparam int c_TICK_DIV   = 20;
    localparam int c_DISP_DIV   = 4;
    localparam int c_NUM_DIGITS = 8;
    localparam int c_RING_SEC   = 60;
    localparam int c_SNOOZE_MIN = 5;

    logic        clk = 1'b0;
    logic        rst, load, alarm_set, alarm_en, snooze, stop, disp_alarm;
    logic [15:0] time_init, alarm_init;
    logic [3:0]  hourdec_now, hourone_now, mindec_now, minone_now;
    logic [7:0]  sec_now;
    logic        ring, load_err;
    logic        CA, CB, CC, CD, CE, CF, CG;
    logic [7:0]  AN;
    logic [23:0] w_now;
    logic [6:0]  w_segs;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } disp_t;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] time_q[$];
    disp_t       disp_q[$];

    assign w_now  = {hourdec_now, hourone_now, mindec_now, minone_now, sec_now};
    assign w_segs = {CA, CB, CC, CD, CE, CF, CG};

    always #5 clk = ~clk;

    alarm_watch_core #(
        .TICK_DIV(c_TICK_DIV), .DISP_DIV(c_DISP_DIV), .NUM_DIGITS(c_NUM_DIGITS),
        .RING_SEC(c_RING_SEC), .SNOOZE_MIN(c_SNOOZE_MIN), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .time_init(time_init),
        .alarm_set(alarm_set), .alarm_init(alarm_init), .alarm_en(alarm_en),
        .snooze(snooze), .stop(stop), .disp_alarm(disp_alarm),
        .hourdec_now(hourdec_now), .hourone_now(hourone_now),
        .mindec_now(mindec_now), .minone_now(minone_now), .sec_now(sec_now),
        .ring(ring), .load_err(load_err),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .AN(AN)
    );

    function automatic int hhmm_secs(input logic [15:0] v);
        int h, m;
        h = 10 * int'(v[15:12]) + int'(v[11:8]);
        m = 10 * int'(v[7:4]) + int'(v[3:0]);
        return h * 3600 + m * 60;
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int t, h, m, sc;
        t  = s % 86400;
        h  = t / 3600;
        m  = (t / 60) % 60;
        sc = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    // Active-high abcdefg patterns; negative or >9 means a dark digit.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'h7E;
            1:       return 7'h30;
            2:       return 7'h6D;
            3:       return 7'h79;
            4:       return 7'h33;
            5:       return 7'h5B;
            6:       return 7'h5F;
            7:       return 7'h70;
            8:       return 7'h7F;
            9:       return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; time_init = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_alarm_set(input logic [15:0] v);
        alarm_set = 1'b1; alarm_init = v;
        tick();
        alarm_set = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; alarm_set = 1'b0; alarm_en = 1'b0;
        snooze = 1'b0; stop = 1'b0; disp_alarm = 1'b0;
        time_init = 16'h0000; alarm_init = 16'h0000;
        repeat (3) tick();
        checks++; if (w_now !== 24'h000000) begin errors++; $display("FAIL reset_time got %h want 000000", w_now); end
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL reset_ring got %b want 0", ring); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b want 0", load_err); end
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", AN); end
        checks++; if (w_segs !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", w_segs); end
        rst = 1'b0;
        for (int i = 0; i < c_DISP_DIV - 1; i++) begin
            tick();
            checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL pre_scan_an cyc%0d got %h want ff", i, AN); end
        end
        tick();
        checks++; if (AN !== 8'hFE) begin errors++; $display("FAIL first_scan_an got %h want fe", AN); end
    endtask

    task automatic test_count();
        logic [23:0] exp;
        do_load(16'h2359);
        time_q.push_back(to_bcd(hhmm_secs(16'h2359) + 1));
        repeat (c_TICK_DIV) tick();
        exp = time_q.pop_front();
        checks++; if (w_now !== exp) begin errors++; $display("FAIL count_1s got %h want %h", w_now, exp); end
        do_load(16'h2359);
        time_q.push_back(to_bcd(hhmm_secs(16'h2359) + 59));
        time_q.push_back(to_bcd(hhmm_secs(16'h2359) + 60));
        repeat (60 * c_TICK_DIV - 1) tick();
        exp = time_q.pop_front();
        checks++; if (w_now !== exp) begin errors++; $display("FAIL count_pre_wrap got %h want %h", w_now, exp); end
        tick();
        exp = time_q.pop_front();
        checks++; if (w_now !== exp) begin errors++; $display("FAIL count_wrap got %h want %h", w_now, exp); end
        do_load(16'h0958);
        time_q.push_back(to_bcd(hhmm_secs(16'h0958) + 125));
        repeat (125 * c_TICK_DIV) tick();
        exp = time_q.pop_front();
        checks++; if (w_now !== exp) begin errors++; $display("FAIL count_hour_carry got %h want %h", w_now, exp); end
    endtask

    task automatic test_load_err();
        logic [15:0] bad_t[3];
        logic [15:0] bad_a[2];
        logic [23:0] exp;
        bad_t = '{16'h2460, 16'h0960, 16'h1a00};
        bad_a = '{16'h1a00, 16'h2400};
        do_load(16'h1234);
        for (int i = 0; i < 3; i++) begin
            time_q.push_back(to_bcd(hhmm_secs(16'h1234)));
            load = 1'b1; time_init = bad_t[i];
            tick();
            load = 1'b0;
            exp = time_q.pop_front();
            checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL load_err_pulse %h got %b want 1", bad_t[i], load_err); end
            checks++; if (w_now !== exp) begin errors++; $display("FAIL load_rejected %h got %h want %h", bad_t[i], w_now, exp); end
            tick();
            checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_width %h got %b want 0", bad_t[i], load_err); end
        end
        do_alarm_set(16'h0730);
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL alarm_valid_err got %b want 0", load_err); end
        for (int i = 0; i < 2; i++) begin
            do_alarm_set(bad_a[i]);
            checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL alarm_err_pulse %h got %b want 1", bad_a[i], load_err); end
            tick();
            checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL alarm_err_width %h got %b want 0", bad_a[i], load_err); end
        end
        // valid load together with a rejected alarm_set
        time_q.push_back(to_bcd(hhmm_secs(16'h0815)));
        load = 1'b1; time_init = 16'h0815; alarm_set = 1'b1; alarm_init = 16'h1a00;
        tick();
        load = 1'b0; alarm_set = 1'b0;
        exp = time_q.pop_front();
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL dual_err got %b want 1", load_err); end
        checks++; if (w_now !== exp) begin errors++; $display("FAIL dual_load got %h want %h", w_now, exp); end
    endtask

    task automatic test_display();
        int    dig_t[8];
        int    dig_a[8];
        int    waited;
        disp_t exp;
        logic [7:0] one;
        one   = 8'h01;
        dig_t = '{-1, -1, 4, 3, 2, 1, -1, -1};
        dig_a = '{-1, -1, 0, 3, 7, 0, -1, -1};
        do_load(16'h1234);
        disp_alarm = 1'b0;
        for (int d = 2; d < 8; d++) disp_q.push_back('{an: ~(one << d), seg: ~seg_of(dig_t[d])});
        waited = 0;
        while (AN !== 8'hFB && waited < 40) begin tick(); waited++; end
        if (AN !== 8'hFB) begin checks++; errors++; $display("FAIL disp_sync_time got %h want fb", AN); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) repeat (c_DISP_DIV) tick();
            exp = disp_q.pop_front();
            checks++; if (AN !== exp.an) begin errors++; $display("FAIL disp_an step%0d got %h want %h", i, AN, exp.an); end
            checks++; if (w_segs !== exp.seg) begin errors++; $display("FAIL disp_seg step%0d got %h want %h", i, w_segs, exp.seg); end
        end
        disp_alarm = 1'b1;
        for (int d = 0; d < 8; d++) disp_q.push_back('{an: ~(one << d), seg: ~seg_of(dig_a[d])});
        waited = 0;
        while (AN !== 8'hFE && waited < 40) begin tick(); waited++; end
        if (AN !== 8'hFE) begin checks++; errors++; $display("FAIL disp_sync_alarm got %h want fe", AN); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat (c_DISP_DIV) tick();
            exp = disp_q.pop_front();
            checks++; if (AN !== exp.an) begin errors++; $display("FAIL alm_an step%0d got %h want %h", i, AN, exp.an); end
            checks++; if (w_segs !== exp.seg) begin errors++; $display("FAIL alm_seg step%0d got %h want %h", i, w_segs, exp.seg); end
        end
        disp_alarm = 1'b0;
    endtask

    task automatic test_alarm();
        logic [23:0] exp;
        alarm_en = 1'b1;
        do_load(16'h0729);
        time_q.push_back(to_bcd(hhmm_secs(16'h0730)));
        repeat (60 * c_TICK_DIV - 1) tick();
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_early got %b want 0", ring); end
        tick();
        exp = time_q.pop_front();
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_rise got %b want 1", ring); end
        checks++; if (w_now !== exp) begin errors++; $display("FAIL ring_time got %h want %h", w_now, exp); end
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL blink_off got %h want ff", AN); end
        repeat (c_TICK_DIV / 2) tick();
        checks++; if (AN === 8'hFF) begin errors++; $display("FAIL blink_on got %h want not ff", AN); end
        repeat (c_RING_SEC * c_TICK_DIV - c_TICK_DIV / 2 - 1) tick();
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_hold got %b want 1", ring); end
        tick();
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_timeout got %b want 0", ring); end
    endtask

    task automatic test_snooze();
        do_load(16'h0729);
        repeat (60 * c_TICK_DIV) tick();
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snz_ring got %b want 1", ring); end
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snz_quiet got %b want 0", ring); end
        repeat (c_SNOOZE_MIN * 60 * c_TICK_DIV - 2) tick();
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snz_early got %b want 0", ring); end
        tick();
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL snz_rering got %b want 1", ring); end
        stop = 1'b1; snooze = 1'b1;
        tick();
        stop = 1'b0; snooze = 1'b0;
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL stop_snz got %b want 0", ring); end
        repeat ((c_SNOOZE_MIN * 60 + 1) * c_TICK_DIV) tick();
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL stop_wins got %b want 0", ring); end
    endtask

    task automatic test_alarm_en();
        logic [23:0] exp;
        alarm_en = 1'b1;
        do_load(16'h0729);
        repeat (60 * c_TICK_DIV) tick();
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL en_ring got %b want 1", ring); end
        alarm_en = 1'b0;
        tick();
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL en_force_idle got %b want 0", ring); end
        do_load(16'h0729);
        time_q.push_back(to_bcd(hhmm_secs(16'h0730)));
        repeat (60 * c_TICK_DIV) tick();
        exp = time_q.pop_front();
        checks++; if (w_now !== exp) begin errors++; $display("FAIL dis_time got %h want %h", w_now, exp); end
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL dis_no_ring got %b want 0", ring); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_load_err();
        test_display();
        test_alarm();
        test_snooze();
        test_alarm_en();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
